// File: rtl/card_txn_controller_pkg.sv
`default_nettype none
// ============================================================================
// card_txn_controller_pkg
// Shared vending definitions: transaction states, timing defaults, widths.
// Revision: 1.0
// ============================================================================
package card_txn_controller_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;
  localparam int MAX_RETRY_DEFAULT      = 2;
  localparam int AMOUNT_W               = 3;
  localparam int TIMER_W                = 8;
  localparam int RETRY_W                = 2;
  localparam int TXN_COUNT_W            = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CARD     = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_APPROVE  = 3'd4,
    ST_DECLINE  = 3'd5,
    ST_HOLD     = 3'd6
  } txn_state_e;

  function automatic logic [TXN_COUNT_W-1:0] sat_inc(input logic [TXN_COUNT_W-1:0] v);
    return (v == {TXN_COUNT_W{1'b1}}) ? v : v + TXN_COUNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_txn_controller_timer.sv
`default_nettype none
// ============================================================================
// txn_timeout_timer
// Per-attempt bank response timer; expired is high on the last wait cycle.
// Revision: 1.0
// ============================================================================
module txn_timeout_timer
  import card_txn_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] C_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != C_LAST)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/card_txn_controller.sv
`default_nettype none
// ============================================================================
// card_txn_controller
// Card payment handshake between the vending FSM and the bank link.
// Revision: 1.0
// ============================================================================
module card_txn_controller
  import card_txn_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int MAX_RETRY      = MAX_RETRY_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CARD_IN,
  input  logic [AMOUNT_W-1:0]    COST,
  input  logic                   BANK_READY,
  input  logic                   BANK_RSP_VALID,
  input  logic                   BANK_RSP_OK,
  output logic                   BANK_REQ,
  output logic [AMOUNT_W-1:0]    BANK_AMOUNT,
  output logic                   VALID_TRAN,
  output logic                   DECLINED,
  output logic                   BUSY,
  output logic [TXN_COUNT_W-1:0] TXN_COUNT
);

  localparam logic [RETRY_W-1:0] C_RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  txn_state_e             state_q, state_d;
  logic [AMOUNT_W-1:0]    amount_q, amount_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [TXN_COUNT_W-1:0] txn_count_q, txn_count_d;
  logic                   bank_req_q, valid_tran_q, declined_q, busy_q;
  logic                   timer_expired;

  txn_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .clear_i   (state_q != ST_WAIT_RSP),
    .enable_i  (state_q == ST_WAIT_RSP),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    amount_d    = amount_q;
    retry_d     = retry_q;
    txn_count_d = txn_count_q;
    case (state_q)
      ST_IDLE: if (CARD_IN) state_d = ST_CARD;
      ST_CARD: begin
        if (!CARD_IN) begin
          state_d = ST_IDLE;
        end else if (COST != '0) begin
          amount_d = COST;
          retry_d  = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!CARD_IN)        state_d = ST_IDLE;
        else if (BANK_READY) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        // Card removal aborts silently; a response beats a same-cycle expiry.
        if (!CARD_IN) begin
          state_d = ST_IDLE;
        end else if (BANK_RSP_VALID) begin
          state_d = BANK_RSP_OK ? ST_APPROVE : ST_DECLINE;
        end else if (timer_expired) begin
          if (retry_q < C_RETRY_LIMIT) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_REQ;
          end else begin
            state_d = ST_DECLINE;
          end
        end
      end
      ST_APPROVE: state_d = ST_HOLD;
      ST_DECLINE: state_d = ST_HOLD;
      ST_HOLD:    if (!CARD_IN || (COST == '0)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (state_d == ST_APPROVE) txn_count_d = sat_inc(txn_count_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      amount_q     <= '0;
      retry_q      <= '0;
      txn_count_q  <= '0;
      bank_req_q   <= 1'b0;
      valid_tran_q <= 1'b0;
      declined_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      amount_q     <= amount_d;
      retry_q      <= retry_d;
      txn_count_q  <= txn_count_d;
      bank_req_q   <= (state_d == ST_REQ);
      valid_tran_q <= (state_d == ST_APPROVE);
      declined_q   <= (state_d == ST_DECLINE);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign BANK_REQ    = bank_req_q;
  assign BANK_AMOUNT = amount_q;
  assign VALID_TRAN  = valid_tran_q;
  assign DECLINED    = declined_q;
  assign BUSY        = busy_q;
  assign TXN_COUNT   = txn_count_q;

endmodule
`default_nettype wire
